// File: rtl/controle_multiciclo.sv
// Multicycle MIPS-style control unit: Moore FSM that sequences fetch, decode,
// execute, memory and write-back steps. A memory access that waits too long
// for mem_ready parks the FSM in HALT with a sticky timeout flag.
// Optional feature: define CONTROLE_ADDI_EN to decode ADDI (opcode 0x08).
module controle_multiciclo #(
    parameter int unsigned WAIT_LIMIT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       ir_write,
    output logic       alu_src_a,
    output logic       reg_write,
    output logic       reg_dst,
    output logic [1:0] pc_source,
    output logic [1:0] alu_op,
    output logic [1:0] alu_src_b,
    output logic [3:0] state,
    output logic       illegal_op,
    output logic       mem_timeout
);

    localparam int unsigned CNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
`ifdef CONTROLE_ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'h08;
`endif

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_HALT      = 4'd15
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_cnt_next;
    logic             r_mem_timeout;
    logic             w_mem_state;
    logic             w_wait_last;
    logic             w_timeout_hit;
    logic             w_illegal;

    // FETCH, MEM_READ and MEM_WRITE are the states that stall on memory
    assign w_mem_state   = (r_state == S_FETCH) || (r_state == S_MEM_READ) ||
                           (r_state == S_MEM_WRITE);
    assign w_wait_last   = (r_wait_cnt == CNT_LAST);
    assign w_timeout_hit = w_mem_state && !mem_ready && w_wait_last;
    // Counter runs only while stalled; any advance or non-memory state clears it
    assign w_wait_cnt_next = (w_mem_state && !mem_ready && !w_wait_last) ?
                             r_wait_cnt + CNT_W'(1) : '0;

    // State, wait counter and sticky timeout registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_FETCH;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_wait_cnt <= w_wait_cnt_next;
            if (w_timeout_hit) begin
                r_mem_timeout <= 1'b1;
            end
        end
    end

    // Next-state decode and the DECODE-cycle illegal opcode flag
    always_comb begin
        w_next    = r_state;
        w_illegal = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (mem_ready)        w_next = S_DECODE;
                else if (w_wait_last) w_next = S_HALT;
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:      w_next = S_R_EXEC;
                    OP_LW, OP_SW:  w_next = S_MEM_ADDR;
                    OP_BEQ:        w_next = S_BRANCH;
                    OP_J:          w_next = S_JUMP;
`ifdef CONTROLE_ADDI_EN
                    OP_ADDI:       w_next = S_ADDI_EXEC;
`endif
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                if (opcode == OP_LW)      w_next = S_MEM_READ;
                else if (opcode == OP_SW) w_next = S_MEM_WRITE;
                else                      w_next = S_FETCH;
            end
            S_MEM_READ: begin
                if (mem_ready)        w_next = S_MEM_WB;
                else if (w_wait_last) w_next = S_HALT;
            end
            S_MEM_WRITE: begin
                if (mem_ready)        w_next = S_FETCH;
                else if (w_wait_last) w_next = S_HALT;
            end
            S_R_EXEC:    w_next = S_R_WB;
            S_ADDI_EXEC: w_next = S_ADDI_WB;
            S_MEM_WB, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP: w_next = S_FETCH;
            S_HALT:      w_next = S_HALT;
            default:     w_next = S_FETCH;
        endcase
    end

    // Moore control decode; FETCH write strobes follow mem_ready but are held low in reset
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        ir_write      = 1'b0;
        alu_src_a     = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        pc_source     = 2'b00;
        alu_op        = 2'b00;
        alu_src_b     = 2'b00;
        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready && reset;
                pc_write  = mem_ready && reset;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEM_ADDR, S_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            S_ADDI_WB: reg_write = 1'b1;
            default: ;
        endcase
    end

    assign state       = r_state;
    assign illegal_op  = w_illegal;
    assign mem_timeout = r_mem_timeout;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Bench for controle_multiciclo: instruction-level model expands each opcode and
// memory wait pattern into the expected per-cycle state walk and control word.
module tb_controle_multiciclo;

    localparam int WAIT_LIMIT = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg;
    logic       ir_write, alu_src_a, reg_write, reg_dst;
    logic [1:0] pc_source, alu_op, alu_src_b;
    logic [3:0] state;
    logic       illegal_op, mem_timeout;
    logic [15:0] w_ctrl;

    int n_cmp  = 0;
    int n_fail = 0;

    controle_multiciclo #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .ir_write(ir_write), .alu_src_a(alu_src_a), .reg_write(reg_write),
        .reg_dst(reg_dst), .pc_source(pc_source), .alu_op(alu_op),
        .alu_src_b(alu_src_b), .state(state), .illegal_op(illegal_op),
        .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    assign w_ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg,
                     ir_write, alu_src_a, reg_write, reg_dst, pc_source, alu_op, alu_src_b};

    function automatic bit legal(logic [5:0] op);
        bit ok;
        ok = (op == 6'h00) || (op == 6'h23) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h02);
`ifdef CONTROLE_ADDI_EN
        ok = ok || (op == 6'h08);
`endif
        return ok;
    endfunction

    // Control word per state as listed in the requirements table
    function automatic logic [15:0] exp_ctrl(int st, bit rdy, bit rst_n);
        bit pw = 0, pwc = 0, iod = 0, mr = 0, mw = 0, mtr = 0, irw = 0, asa = 0, rw = 0, rd = 0;
        logic [1:0] ps = 2'b00, aop = 2'b00, asb = 2'b00;
        case (st)
            0:  begin mr = 1; asb = 2'b01; pw = rdy && rst_n; irw = rdy && rst_n; end
            1:  asb = 2'b11;
            2, 10: begin asa = 1; asb = 2'b10; end
            3:  begin mr = 1; iod = 1; end
            4:  begin rw = 1; mtr = 1; end
            5:  begin mw = 1; iod = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin asa = 1; aop = 2'b01; pwc = 1; ps = 2'b01; end
            9:  begin pw = 1; ps = 2'b10; end
            11: rw = 1;
            default: ;
        endcase
        return {pw, pwc, iod, mr, mw, mtr, irw, asa, rw, rd, ps, aop, asb};
    endfunction

    task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h op=%h t=%0t", tag, obs, exp, opcode, $time);
        end
    endtask

    // One clock of the walk: drive mem_ready, check mid-cycle, advance past the edge
    task automatic step(int st, bit rdy);
        mem_ready = rdy;
        @(negedge clk);
        check("state", 16'(state), 16'(st));
        check("ctrl", w_ctrl, exp_ctrl(st, rdy, 1'b1));
        check("illegal_op", 16'(illegal_op), 16'(st == 1 && !legal(opcode)));
        check("mem_timeout", 16'(mem_timeout), 16'(st == 15));
        @(posedge clk);
        #1;
    endtask

    // Memory stall: `waits` cycles without ready, then ready; WAIT_LIMIT stalls -> HALT
    task automatic mem_phase(int st, int waits, output bit halted);
        halted = 1'b0;
        if (waits >= WAIT_LIMIT) begin
            for (int i = 0; i < WAIT_LIMIT; i++) step(st, 1'b0);
            for (int i = 0; i < 3; i++) step(15, 1'($urandom_range(0, 1)));
            halted = 1'b1;
        end else begin
            for (int i = 0; i < waits; i++) step(st, 1'b0);
            step(st, 1'b1);
        end
    endtask

    task automatic run_instr(logic [5:0] op, int wf, int wm, output bit halted);
        opcode = op;
        mem_phase(0, wf, halted);
        if (halted) return;
        step(1, 1'($urandom_range(0, 1)));
        if (!legal(op)) return;
        case (op)
            6'h00: begin step(6, 1'($urandom_range(0, 1))); step(7, 1'($urandom_range(0, 1))); end
            6'h23: begin
                step(2, 1'($urandom_range(0, 1)));
                mem_phase(3, wm, halted);
                if (!halted) step(4, 1'($urandom_range(0, 1)));
            end
            6'h2B: begin step(2, 1'($urandom_range(0, 1))); mem_phase(5, wm, halted); end
            6'h04: step(8, 1'($urandom_range(0, 1)));
            6'h02: step(9, 1'($urandom_range(0, 1)));
            6'h08: begin step(10, 1'($urandom_range(0, 1))); step(11, 1'($urandom_range(0, 1))); end
            default: ;
        endcase
    endtask

    // Assert reset between edges, check FETCH-in-reset outputs, release between edges
    task automatic do_reset();
        reset = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("rst_state", 16'(state), 16'd0);
        check("rst_ctrl", w_ctrl, exp_ctrl(0, 1'b1, 1'b0));
        check("rst_illegal", 16'(illegal_op), 16'd0);
        check("rst_timeout", 16'(mem_timeout), 16'd0);
        @(posedge clk);
        #1;
        check("rst_hold_state", 16'(state), 16'd0);
        reset = 1'b1;
    endtask

    function automatic int rand_wait();
        if ($urandom_range(0, 9) < 7) return int'($urandom_range(0, 3));
        return int'($urandom_range(WAIT_LIMIT - 1, WAIT_LIMIT + 1));
    endfunction

    function automatic logic [5:0] rand_op();
        case ($urandom_range(0, 6))
            0: return 6'h00;
            1: return 6'h23;
            2: return 6'h2B;
            3: return 6'h04;
            4: return 6'h02;
            5: return 6'h08;
            default: return 6'($urandom_range(0, 63));
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit h;
        reset = 1'b0;
        opcode = 6'h00;
        mem_ready = 1'b1;
        #3;
        check("init_state", 16'(state), 16'd0);
        check("init_ctrl", w_ctrl, exp_ctrl(0, 1'b1, 1'b0));
        check("init_timeout", 16'(mem_timeout), 16'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        run_instr(6'h00, 0, 0, h);                 // R-type straight through
        run_instr(6'h23, 0, 3, h);                 // load with 3 stall cycles
        run_instr(6'h23, 2, WAIT_LIMIT - 1, h);    // ready on the limit cycle
        run_instr(6'h3F, 0, 0, h);                 // illegal opcode
        run_instr(6'h08, 0, 0, h);                 // ADDI or illegal by build
        run_instr(6'h04, 1, 0, h);                 // branch
        run_instr(6'h02, 0, 0, h);                 // jump
        run_instr(6'h2B, 0, WAIT_LIMIT, h);        // store timeout -> HALT
        if (h) do_reset();
        run_instr(6'h00, WAIT_LIMIT, 0, h);        // fetch timeout -> HALT
        if (h) do_reset();

        // Reset pulled mid-MEM_READ while a wait is pending
        opcode = 6'h23;
        step(0, 1'b1);
        step(1, 1'b0);
        step(2, 1'b0);
        step(3, 1'b0);
        do_reset();
        run_instr(6'h2B, 0, 2, h);

        for (int n = 0; n < 80; n++) begin
            run_instr(rand_op(), rand_wait(), rand_wait(), h);
            if (h) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
